fetch_pc_gen: RTL and testbench

- IF-stage next-PC generator. Holds the architectural fetch PC and a direct-mapped branch target buffer (BTB).
- Drives the pc/is_branch pair that the 2-bit direction predictor reads, and consumes the predictor's combinational prediction to choose the next fetch address.
- Resolves EX-stage outcomes into mispredict redirects, a pipeline flush and BTB updates.
- Keeps branch and mispredict performance counters.

---
 rtl/fetch_pc_gen.sv | 152 +++++++++++++++
 tb/tb_fetch_pc_gen.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_gen.sv
// ---------------------------------------------------------------------------
// fetch_pc_gen
//
// IF-stage next-PC generator. Holds the architectural fetch PC and a
// direct-mapped branch target buffer (BTB). Each cycle the BTB is probed with
// the current pc. The external 2-bit direction predictor answers with
// 'prediction', and that answer chooses between the BTB target and pc+4.
// Branches resolved in EX are turned into mispredict redirects, a pipeline
// flush and BTB updates. The block also keeps branch and mispredict counters.
//
// Ports:
//   clk, rstn        clock, asynchronous active-low reset
//   stall            hazard unit freeze of the IF stage
//   pc               current fetch PC (to predictor and I-memory)
//   is_branch        BTB hit for pc (to predictor)
//   prediction       predictor taken/not-taken for pc (combinational)
//   pred_taken_IF    is_branch & prediction, carried down the pipe
//   pred_target_IF   predicted next fetch address, carried down the pipe
//   pc_EX ..         resolved branch information from the EX stage
//   pred_*_EX        IF-stage prediction carried along to EX
//   flush            kill IF/ID and ID/EX contents (same cycle as mispredict)
//   branch_cnt       resolved branches since reset
//   mispred_cnt      mispredicts since reset
// ---------------------------------------------------------------------------
module fetch_pc_gen #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BTB_IDX_W = 4,
    parameter int          CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             stall,
    output logic [31:0]      pc,
    output logic             is_branch,
    input  logic             prediction,
    output logic             pred_taken_IF,
    output logic [31:0]      pred_target_IF,
    input  logic [31:0]      pc_EX,
    input  logic             branch_EX,
    input  logic             btaken_EX,
    input  logic [31:0]      btarget_EX,
    input  logic             pred_taken_EX,
    input  logic [31:0]      pred_target_EX,
    output logic             flush,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam int TAG_W   = 32 - BTB_IDX_W - 2;
    localparam int ENTRIES = 1 << BTB_IDX_W;

    logic             btb_valid  [ENTRIES];
    logic [TAG_W-1:0] btb_tag    [ENTRIES];
    logic [31:0]      btb_target [ENTRIES];

    logic [BTB_IDX_W-1:0] fetch_idx;
    logic [TAG_W-1:0]     fetch_tag;
    logic [BTB_IDX_W-1:0] ex_idx;
    logic [TAG_W-1:0]     ex_tag;
    logic [31:0]          pc_plus4;
    logic [31:0]          redirect_pc;
    logic                 mispredict;
    logic                 btb_write;
    logic [31:0]          next_pc;

    // Word-aligned index and tag slices for both the fetch lookup and the
    // EX-side update. The two low address bits never take part in either.
    always_comb begin
        fetch_idx = pc[BTB_IDX_W+1:2];
        fetch_tag = pc[31:BTB_IDX_W+2];
        ex_idx    = pc_EX[BTB_IDX_W+1:2];
        ex_tag    = pc_EX[31:BTB_IDX_W+2];
    end

    // Fetch-side prediction. The lookup reads the registered BTB contents,
    // so an update written in the same cycle becomes visible one cycle later.
    always_comb begin
        pc_plus4       = pc + 32'd4;
        is_branch      = btb_valid[fetch_idx] && (btb_tag[fetch_idx] == fetch_tag);
        pred_taken_IF  = is_branch & prediction;
        pred_target_IF = pred_taken_IF ? btb_target[fetch_idx] : pc_plus4;
    end

    // EX-side resolution. A taken branch that was predicted taken still
    // counts as a mispredict when the predicted target differs from the real
    // one, for example after the BTB entry was replaced by an aliasing branch.
    always_comb begin
        mispredict  = branch_EX &
                      ((btaken_EX != pred_taken_EX) |
                       (btaken_EX & (btarget_EX != pred_target_EX)));
        flush       = mispredict;
        redirect_pc = btaken_EX ? btarget_EX : (pc_EX + 32'd4);
        btb_write   = branch_EX & btaken_EX;
    end

    // Next-PC selection. A mispredict must win over stall, otherwise a frozen
    // IF stage would keep fetching down the wrong path after the flush.
    always_comb begin
        next_pc = pc_plus4;
        if (mispredict) begin
            next_pc = redirect_pc;
        end else if (stall) begin
            next_pc = pc;
        end else if (pred_taken_IF) begin
            next_pc = btb_target[fetch_idx];
        end
    end

    // Fetch PC register. Reset also discards any redirect that is pending
    // in the same cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc <= RESET_PC;
        end else begin
            pc <= next_pc;
        end
    end

    // BTB storage. Only taken branches allocate; the new entry simply
    // overwrites whatever occupied the slot. Updates ignore stall because EX
    // resolution is independent of the IF freeze.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < ENTRIES; i++) begin
                btb_valid[i]  <= 1'b0;
                btb_tag[i]    <= '0;
                btb_target[i] <= '0;
            end
        end else if (btb_write) begin
            btb_valid[ex_idx]  <= 1'b1;
            btb_tag[ex_idx]    <= ex_tag;
            btb_target[ex_idx] <= btarget_EX;
        end
    end

    // Performance counters. EX presents each branch for exactly one cycle,
    // so counting cycles counts instructions. Both wrap naturally.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else begin
            if (branch_EX) begin
                branch_cnt <= branch_cnt + CNT_W'(1);
            end
            if (mispredict) begin
                mispred_cnt <= mispred_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// ---------------------------------------------------------------------------
// tb_fetch_pc_gen
//
// Self-checking bench for fetch_pc_gen. It keeps a reference model of the
// fetch PC, a BTB held as associative arrays keyed by slot number, and the
// two counters. Directed sequences reproduce the scenarios of interest, and
// randomized cycles then exercise the priority rules and aliasing.
// ---------------------------------------------------------------------------
module tb_fetch_pc_gen;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rstn;
    logic        stall;
    logic [31:0] pc;
    logic        is_branch;
    logic        prediction;
    logic        pred_taken_IF;
    logic [31:0] pred_target_IF;
    logic [31:0] pc_EX;
    logic        branch_EX;
    logic        btaken_EX;
    logic [31:0] btarget_EX;
    logic        pred_taken_EX;
    logic [31:0] pred_target_EX;
    logic        flush;
    logic [31:0] branch_cnt;
    logic [31:0] mispred_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_brCnt;
    logic [31:0] m_misCnt;
    logic [31:0] btbPc  [int];
    logic [31:0] btbTgt [int];

    fetch_pc_gen #(
        .RESET_PC (RST_PC),
        .BTB_IDX_W(4),
        .CNT_W    (32)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .stall         (stall),
        .pc            (pc),
        .is_branch     (is_branch),
        .prediction    (prediction),
        .pred_taken_IF (pred_taken_IF),
        .pred_target_IF(pred_target_IF),
        .pc_EX         (pc_EX),
        .branch_EX     (branch_EX),
        .btaken_EX     (btaken_EX),
        .btarget_EX    (btarget_EX),
        .pred_taken_EX (pred_taken_EX),
        .pred_target_EX(pred_target_EX),
        .flush         (flush),
        .branch_cnt    (branch_cnt),
        .mispred_cnt   (mispred_cnt)
    );

    always #5 clk = ~clk;

    // One comparison: counts it and reports a mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // A 16-entry direct-mapped table: the slot is the word address modulo 16.
    function automatic int slotOf(input logic [31:0] a);
        return int'((a >> 2) % 32'd16);
    endfunction

    // Two addresses share an entry only if they are the same word.
    function automatic logic modelHit(input logic [31:0] a);
        int s;
        s = slotOf(a);
        return btbPc.exists(s) && ((btbPc[s] >> 2) == (a >> 2));
    endfunction

    task automatic modelReset();
        m_pc     = RST_PC;
        m_brCnt  = 0;
        m_misCnt = 0;
        btbPc.delete();
        btbTgt.delete();
    endtask

    // Drives one cycle of inputs at the falling edge, checks the
    // combinational outputs, steps the model and checks the registered state.
    task automatic applyStimulus(input logic st, input logic pr, input logic br,
                                 input logic bt, input logic [31:0] btg,
                                 input logic [31:0] pex, input logic ptex,
                                 input logic [31:0] ptgex);
        logic        hit;
        logic        ePt;
        logic [31:0] eTgt;
        logic        eMis;
        logic [31:0] nPc;
        @(negedge clk);
        stall          = st;
        prediction     = pr;
        branch_EX      = br;
        btaken_EX      = bt;
        btarget_EX     = btg;
        pc_EX          = pex;
        pred_taken_EX  = ptex;
        pred_target_EX = ptgex;
        #1;
        hit  = modelHit(m_pc);
        ePt  = hit && pr;
        eTgt = ePt ? btbTgt[slotOf(m_pc)] : m_pc + 32'd4;
        eMis = br && ((bt != ptex) || (bt && (btg != ptgex)));
        checkOutput("is_branch", {31'd0, is_branch}, {31'd0, hit});
        checkOutput("pred_taken_IF", {31'd0, pred_taken_IF}, {31'd0, ePt});
        checkOutput("pred_target_IF", pred_target_IF, eTgt);
        checkOutput("flush", {31'd0, flush}, {31'd0, eMis});
        if (eMis)     nPc = bt ? btg : pex + 32'd4;
        else if (st)  nPc = m_pc;
        else if (ePt) nPc = eTgt;
        else          nPc = m_pc + 32'd4;
        if (br && bt) begin
            btbPc[slotOf(pex)]  = pex;
            btbTgt[slotOf(pex)] = btg;
        end
        if (br)   m_brCnt  = m_brCnt + 1;
        if (eMis) m_misCnt = m_misCnt + 1;
        m_pc = nPc;
        @(posedge clk);
        #1;
        checkOutput("pc", pc, m_pc);
        checkOutput("branch_cnt", branch_cnt, m_brCnt);
        checkOutput("mispred_cnt", mispred_cnt, m_misCnt);
    endtask

    task automatic idleCycle(input logic pr);
        applyStimulus(1'b0, pr, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    endtask

    // Forces fetch to 'a' with a not-taken branch that was predicted taken.
    task automatic redirectTo(input logic [31:0] a);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'd0, a - 32'd4, 1'b1, 32'h0000_0ff0);
    endtask

    task automatic randomCycles(input int n);
        logic        st, pr, br, bt, ptex;
        logic [31:0] btg, pex, ptgex;
        for (int i = 0; i < n; i++) begin
            st    = ($urandom_range(0, 3) == 0);
            pr    = 1'($urandom_range(0, 1));
            br    = ($urandom_range(0, 9) < 4);
            bt    = 1'($urandom_range(0, 1));
            pex   = (($urandom_range(0, 1) == 1) ? 32'h500 : 32'h100) + 32'($urandom_range(0, 31) * 4);
            btg   = 32'h100 + 32'($urandom_range(0, 63) * 4);
            ptex  = 1'($urandom_range(0, 1));
            ptgex = ($urandom_range(0, 1) == 1) ? btg : 32'h100 + 32'($urandom_range(0, 63) * 4);
            // Keep fetch roughly inside the branch region so BTB hits happen.
            if (m_pc > 32'h800 && !br) begin
                br = 1'b1; bt = 1'b1; ptex = 1'b0;
            end
            applyStimulus(st, pr, br, bt, btg, pex, ptex, ptgex);
        end
    endtask

    initial begin
        rstn           = 1'b0;
        stall          = 1'b0;
        prediction     = 1'b0;
        branch_EX      = 1'b0;
        btaken_EX      = 1'b0;
        btarget_EX     = '0;
        pc_EX          = '0;
        pred_taken_EX  = 1'b0;
        pred_target_EX = '0;
        modelReset();

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("reset_pc", pc, RST_PC);
        checkOutput("reset_is_branch", {31'd0, is_branch}, 32'd0);
        checkOutput("reset_pred_target", pred_target_IF, RST_PC + 32'd4);
        checkOutput("reset_flush", {31'd0, flush}, 32'd0);
        checkOutput("reset_branch_cnt", branch_cnt, 32'd0);
        checkOutput("reset_mispred_cnt", mispred_cnt, 32'd0);
        @(posedge clk);
        #1 rstn = 1'b1;

        // Sequential fetch from an empty BTB
        idleCycle(1'b1);
        checkOutput("seq_pc_104", pc, 32'h104);

        // Taken branch at 0x104 predicted not-taken: redirect and allocate
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 32'h200, 32'h104, 1'b0, 32'h108);
        checkOutput("redir_pc_200", pc, 32'h200);
        checkOutput("redir_mispred_1", mispred_cnt, 32'd1);

        // Fetch 0x104 again: predicted taken with zero bubbles
        redirectTo(32'h104);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
        checkOutput("hit_taken_pc_200", pc, 32'h200);

        // Same fetch with the predictor saying not-taken
        redirectTo(32'h104);
        idleCycle(1'b0);
        checkOutput("hit_nt_pc_108", pc, 32'h108);

        // Not-taken mispredict while stalled: redirect beats stall
        redirectTo(32'h104);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h200, 32'h104, 1'b1, 32'h200);
        checkOutput("stall_redir_pc_108", pc, 32'h108);

        // Correct taken prediction under stall: no flush, pc holds
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 32'h200, 32'h104, 1'b1, 32'h200);
        checkOutput("correct_hold_pc", pc, 32'h108);

        // Aliasing branch at 0x504 replaces the 0x104 entry
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 32'h600, 32'h504, 1'b0, 32'h508);
        redirectTo(32'h104);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
        checkOutput("alias_pc_108", pc, 32'h108);

        // Wrap of the PC at the top of the address space
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 32'h300, 1'b0, 32'h304);
        idleCycle(1'b0);
        checkOutput("wrap_pc_0", pc, 32'h0);

        redirectTo(32'h104);
        randomCycles(600);

        // Asynchronous reset in the middle of a mispredict cycle
        @(negedge clk);
        branch_EX     = 1'b1;
        btaken_EX     = 1'b1;
        btarget_EX    = 32'h340;
        pc_EX         = 32'h120;
        pred_taken_EX = 1'b0;
        stall         = 1'b0;
        #1;
        checkOutput("pre_reset_flush", {31'd0, flush}, 32'd1);
        #1 rstn = 1'b0;
        #1;
        checkOutput("areset_pc", pc, RST_PC);
        checkOutput("areset_branch_cnt", branch_cnt, 32'd0);
        checkOutput("areset_mispred_cnt", mispred_cnt, 32'd0);
        checkOutput("areset_is_branch", {31'd0, is_branch}, 32'd0);
        branch_EX = 1'b0;
        #1;
        checkOutput("areset_flush", {31'd0, flush}, 32'd0);
        modelReset();
        @(posedge clk);
        #1;
        checkOutput("areset_pc_held", pc, RST_PC);
        rstn = 1'b1;

        // BTB must be empty again: fetching the formerly cached 0x504 misses
        redirectTo(32'h504);
        idleCycle(1'b1);
        checkOutput("post_reset_pc", pc, 32'h508);
        randomCycles(200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
